swd_txn_ctrl: RTL and testbench



---
 rtl/swd_txn_ctrl.sv | 173 +++++++++++++++++
 tb/tb_swd_txn_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swd_txn_ctrl.sv
// SWD transaction controller: turns host requests into PHY shift commands, retries WAIT
// acknowledges up to RETRY_MAX times and returns one response per request.
module swd_txn_ctrl #(
  parameter int unsigned RETRY_MAX = 15
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_LRESET,
  input  logic        REQ_APNDP,
  input  logic        REQ_RNW,
  input  logic [1:0]  REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic [2:0]  RSP_ERR,
  output logic        PHY_VALID,
  output logic [5:0]  PHY_T0,
  output logic [5:0]  PHY_T1,
  output logic [63:0] PHY_SO,
  output logic [5:0]  PHY_LEN,
  input  logic [35:0] PHY_SI,
  input  logic        PHY_READY,
  input  logic [2:0]  PHY_ERR
);

  typedef enum logic [2:0] {StIdle, StIssue, StBusy, StEval, StResp} state_e;

  state_e      state_q, state_d;
  logic        lreset_q, lreset_d;
  logic        rnw_q, rnw_d;
  logic [3:0]  retry_q, retry_d;
  logic [5:0]  t0_q, t0_d, t1_q, t1_d, len_q, len_d;
  logic [63:0] so_q, so_d;
  logic [32:0] si_q, si_d;
  logic [2:0]  perr_q, perr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  err_q, err_d;
  logic [7:0]  hdr;
  logic [31:0] rd;
  logic        unused_si;

  // Upper PHY_SI bits carry the acknowledge, already decoded by the PHY into PHY_ERR.
  assign unused_si = ^PHY_SI[35:33];

  assign hdr = {1'b1, 1'b0, ^{REQ_ADDR, REQ_RNW, REQ_APNDP}, REQ_ADDR[1], REQ_ADDR[0],
                REQ_RNW, REQ_APNDP, 1'b1};

  // Read data arrives LSB first right after the acknowledge; bit 0 is the parity bit.
  always_comb begin
    rd = '0;
    for (int i = 0; i < 32; i++) rd[i] = si_q[32-i];
  end

  always_comb begin
    state_d  = state_q;
    lreset_d = lreset_q;
    rnw_d    = rnw_q;
    retry_d  = retry_q;
    t0_d     = t0_q;
    t1_d     = t1_q;
    len_d    = len_q;
    so_d     = so_q;
    si_d     = si_q;
    perr_d   = perr_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (REQ_VALID) begin
          state_d  = StIssue;
          lreset_d = REQ_LRESET;
          rnw_d    = REQ_RNW;
          retry_d  = 4'd0;
          if (REQ_LRESET) begin
            len_d = 6'd58;
            t0_d  = 6'd0;
            t1_d  = 6'd63;
            so_d  = {14'b0, {50{1'b1}}};
          end else if (REQ_RNW) begin
            len_d = 6'd46;
            t0_d  = 6'd8;
            t1_d  = 6'd45;
            so_d  = {56'b0, hdr};
          end else begin
            len_d = 6'd46;
            t0_d  = 6'd8;
            t1_d  = 6'd12;
            so_d  = {23'b0, ^REQ_WDATA, REQ_WDATA, hdr};
          end
        end
      end
      StIssue: if (!PHY_READY) state_d = StBusy;
      StBusy: begin
        if (PHY_READY) begin
          state_d = StEval;
          si_d    = PHY_SI[32:0];
          perr_d  = PHY_ERR;
        end
      end
      StEval: begin
        state_d = StResp;
        rdata_d = '0;
        err_d   = 3'd0;
        if (!lreset_q) begin
          case (perr_q)
            3'd0: begin
              if (rnw_q) begin
                rdata_d = rd;
                err_d   = (si_q[0] != ^rd) ? 3'd4 : 3'd0;
              end
            end
            3'd2: begin
              if (32'(retry_q) < RETRY_MAX) begin
                retry_d = retry_q + 4'd1;
                state_d = StIssue;
              end else begin
                err_d = 3'd2;
              end
            end
            3'd1, 3'd3, 3'd7: err_d = perr_q;
            default:          err_d = 3'd7;
          endcase
        end
      end
      StResp: if (RSP_READY) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q  <= StIdle;
      lreset_q <= 1'b0;
      rnw_q    <= 1'b0;
      retry_q  <= 4'd0;
      t0_q     <= '0;
      t1_q     <= '0;
      len_q    <= '0;
      so_q     <= '0;
      si_q     <= '0;
      perr_q   <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      lreset_q <= lreset_d;
      rnw_q    <= rnw_d;
      retry_q  <= retry_d;
      t0_q     <= t0_d;
      t1_q     <= t1_d;
      len_q    <= len_d;
      so_q     <= so_d;
      si_q     <= si_d;
      perr_q   <= perr_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign REQ_READY = (state_q == StIdle);
  assign RSP_VALID = (state_q == StResp);
  assign PHY_VALID = (state_q == StIssue);
  assign PHY_T0    = t0_q;
  assign PHY_T1    = t1_q;
  assign PHY_LEN   = len_q;
  assign PHY_SO    = so_q;
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;

endmodule

// File: tb/tb_swd_txn_ctrl.sv
// Directed bench for swd_txn_ctrl: a scripted PHY responder plus a linear sequence of
// requests checked with immediate assertions.
module tb_swd_txn_ctrl;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        REQ_VALID, REQ_READY, REQ_LRESET, REQ_APNDP, REQ_RNW;
  logic [1:0]  REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID, RSP_READY;
  logic [31:0] RSP_RDATA;
  logic [2:0]  RSP_ERR;
  logic        PHY_VALID;
  logic [5:0]  PHY_T0, PHY_T1, PHY_LEN;
  logic [63:0] PHY_SO;
  logic [35:0] PHY_SI;
  logic        PHY_READY;
  logic [2:0]  PHY_ERR;

  swd_txn_ctrl #(.RETRY_MAX(2)) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_LRESET(REQ_LRESET),
    .REQ_APNDP (REQ_APNDP),
    .REQ_RNW   (REQ_RNW),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_RDATA (RSP_RDATA),
    .RSP_ERR   (RSP_ERR),
    .PHY_VALID (PHY_VALID),
    .PHY_T0    (PHY_T0),
    .PHY_T1    (PHY_T1),
    .PHY_SO    (PHY_SO),
    .PHY_LEN   (PHY_LEN),
    .PHY_SI    (PHY_SI),
    .PHY_READY (PHY_READY),
    .PHY_ERR   (PHY_ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_mis = 0;

  // PHY script, written by the main sequence only
  int          n_waits = 0;
  logic [2:0]  fin_err = 3'd0;
  logic [35:0] fin_si = '0;
  int          busy_cycles = 3;
  int          txn_base = 0;
  int          unst_base = 0;

  // PHY observations, written by the responder only
  int          cmd_total = 0;
  int          unstable_total = 0;
  logic [63:0] cap_so = '0;
  logic [5:0]  cap_t0 = '0, cap_t1 = '0, cap_len = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] mk_si(input logic [31:0] d, input logic flip);
    logic [35:0] si;
    si = '0;
    for (int i = 0; i < 32; i++) si[32-i] = d[i];
    si[0] = (^d) ^ flip;
    return si;
  endfunction

  // PHY responder: accepts a command, stays busy, then answers from the script.
  initial begin
    int  k;
    int  c;
    bit  aborted;
    PHY_READY = 1'b1;
    PHY_SI    = '0;
    PHY_ERR   = 3'd0;
    forever begin
      @(negedge CLK);
      if (RESETn && PHY_VALID && PHY_READY) begin
        k = cmd_total - txn_base;
        cmd_total++;
        cap_so = PHY_SO; cap_t0 = PHY_T0; cap_t1 = PHY_T1; cap_len = PHY_LEN;
        @(posedge CLK); #1 PHY_READY = 1'b0;
        @(posedge CLK);
        aborted = 1'b0;
        c = 0;
        while (c < busy_cycles && !aborted) begin
          @(negedge CLK);
          if (!RESETn) aborted = 1'b1;
          else if (PHY_VALID || PHY_SO !== cap_so || PHY_T0 !== cap_t0 ||
                   PHY_T1 !== cap_t1 || PHY_LEN !== cap_len) unstable_total++;
          c++;
        end
        if (aborted) begin
          PHY_READY = 1'b1; PHY_ERR = 3'd0; PHY_SI = '0;
        end else begin
          @(posedge CLK); #1;
          PHY_SI    = fin_si;
          PHY_ERR   = (k < n_waits) ? 3'd2 : fin_err;
          PHY_READY = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic lr, input logic ap, input logic rnw, input logic [1:0] addr,
                      input logic [31:0] wd);
    txn_base  = cmd_total;
    unst_base = unstable_total;
    @(posedge CLK); #1;
    REQ_LRESET = lr; REQ_APNDP = ap; REQ_RNW = rnw; REQ_ADDR = addr; REQ_WDATA = wd;
    REQ_VALID = 1'b1;
    @(posedge CLK); #1 REQ_VALID = 1'b0;
    @(negedge CLK);
    check("accept_to_phy_valid", 64'({PHY_VALID, REQ_READY}), 64'(2'b10));
  endtask

  task automatic wait_rsp();
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    while (!got && n < 400) begin
      @(negedge CLK);
      if (RSP_VALID) got = 1'b1;
      n++;
    end
    check("rsp_arrives", 64'(got), 64'(1));
    check("rsp_excl_ready", 64'(REQ_READY), 64'(0));
    check("phy_cmd_stable", 64'(unstable_total - unst_base), 64'(0));
  endtask

  task automatic release_rsp();
    @(posedge CLK); #1 RSP_READY = 1'b1;
    @(posedge CLK); #1 RSP_READY = 1'b0;
    @(negedge CLK);
    check("back_to_idle", 64'({REQ_READY, RSP_VALID}), 64'(2'b10));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 64'(REQ_READY), 64'(1));
    check({tag, "_rsp_valid"}, 64'(RSP_VALID), 64'(0));
    check({tag, "_rsp_rdata"}, 64'(RSP_RDATA), 64'(0));
    check({tag, "_rsp_err"}, 64'(RSP_ERR), 64'(0));
    check({tag, "_phy_valid"}, 64'(PHY_VALID), 64'(0));
    check({tag, "_phy_t0_t1_len"}, 64'({PHY_T0, PHY_T1, PHY_LEN}), 64'(0));
    check({tag, "_phy_so"}, PHY_SO, 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int n;
    RESETn = 1'b0; REQ_VALID = 1'b0; REQ_LRESET = 1'b0; REQ_APNDP = 1'b0; REQ_RNW = 1'b0;
    REQ_ADDR = 2'd0; REQ_WDATA = '0; RSP_READY = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_vals("reset");
    @(posedge CLK); #1 RESETn = 1'b1;

    // Write DP A[3:2]=01, data 1: header bits start,0,0,1,0,par=1,stop,park = 0xA9
    n_waits = 0; fin_err = 3'd0; fin_si = '0;
    send(1'b0, 1'b0, 1'b0, 2'b01, 32'h0000_0001);
    wait_rsp();
    check("wr_cmd_count", 64'(cmd_total - txn_base), 64'(1));
    check("wr_so", cap_so, 64'h0000_0100_0000_01A9);
    check("wr_len_t0_t1", 64'({cap_len, cap_t0, cap_t1}), 64'({6'd46, 6'd8, 6'd12}));
    check("wr_err", 64'(RSP_ERR), 64'(0));
    check("wr_rdata", 64'(RSP_RDATA), 64'(0));
    release_rsp();

    // Read AP addr 3, good parity
    fin_si = mk_si(32'h1234_5678, 1'b0);
    send(1'b0, 1'b1, 1'b1, 2'b11, 32'h0);
    wait_rsp();
    check("rd_so", cap_so, 64'h0000_0000_0000_009F);
    check("rd_len_t0_t1", 64'({cap_len, cap_t0, cap_t1}), 64'({6'd46, 6'd8, 6'd45}));
    check("rd_rdata", 64'(RSP_RDATA), 64'h1234_5678);
    check("rd_err", 64'(RSP_ERR), 64'(0));
    release_rsp();

    // Same read, parity flipped: error 4 but raw data returned
    fin_si = mk_si(32'h1234_5678, 1'b1);
    send(1'b0, 1'b1, 1'b1, 2'b11, 32'h0);
    wait_rsp();
    check("rdpar_err", 64'(RSP_ERR), 64'(4));
    check("rdpar_rdata", 64'(RSP_RDATA), 64'h1234_5678);
    release_rsp();

    // WAIT three times with two retries allowed
    n_waits = 3; fin_err = 3'd0; fin_si = '0;
    send(1'b0, 1'b0, 1'b0, 2'b00, 32'hA5A5_0F0F);
    wait_rsp();
    check("wait3_cmd_count", 64'(cmd_total - txn_base), 64'(3));
    check("wait3_err", 64'(RSP_ERR), 64'(2));
    check("wait3_rdata", 64'(RSP_RDATA), 64'(0));
    release_rsp();

    // WAIT, WAIT, then OK
    n_waits = 2;
    send(1'b0, 1'b0, 1'b0, 2'b10, 32'h0000_00FF);
    wait_rsp();
    check("wait2ok_cmd_count", 64'(cmd_total - txn_base), 64'(3));
    check("wait2ok_err", 64'(RSP_ERR), 64'(0));
    release_rsp();

    // FAULT on a write: no retry
    n_waits = 0; fin_err = 3'd1;
    send(1'b0, 1'b1, 1'b0, 2'b01, 32'h1111_2222);
    wait_rsp();
    check("fault_cmd_count", 64'(cmd_total - txn_base), 64'(1));
    check("fault_err", 64'(RSP_ERR), 64'(1));
    release_rsp();

    // Undefined PHY_ERR 5 on a read maps to 7 with zero data
    fin_err = 3'd5; fin_si = mk_si(32'hDEAD_BEEF, 1'b0);
    send(1'b0, 1'b0, 1'b1, 2'b00, 32'h0);
    wait_rsp();
    check("err5_cmd_count", 64'(cmd_total - txn_base), 64'(1));
    check("err5_err", 64'(RSP_ERR), 64'(7));
    check("err5_rdata", 64'(RSP_RDATA), 64'(0));
    release_rsp();

    // No-connect on a read
    fin_err = 3'd3;
    send(1'b0, 1'b0, 1'b1, 2'b01, 32'h0);
    wait_rsp();
    check("noconn_err", 64'(RSP_ERR), 64'(3));
    check("noconn_rdata", 64'(RSP_RDATA), 64'(0));
    release_rsp();

    // Line reset with junk in the other fields; PHY error ignored
    fin_err = 3'd1; fin_si = mk_si(32'hFFFF_FFFF, 1'b0);
    send(1'b1, 1'b1, 1'b1, 2'b11, 32'hFFFF_FFFF);
    wait_rsp();
    check("lr_so", cap_so, 64'h0003_FFFF_FFFF_FFFF);
    check("lr_len_t0_t1", 64'({cap_len, cap_t0, cap_t1}), 64'({6'd58, 6'd0, 6'd63}));
    check("lr_err", 64'(RSP_ERR), 64'(0));
    check("lr_rdata", 64'(RSP_RDATA), 64'(0));
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("lr_rsp_hold", 64'({RSP_VALID, REQ_READY}), 64'(2'b10));
    end
    release_rsp();

    // Read leaving nonzero state behind, then reset while the PHY is busy
    fin_err = 3'd0; fin_si = mk_si(32'hCAFE_F00D, 1'b0);
    send(1'b0, 1'b1, 1'b1, 2'b10, 32'h0);
    wait_rsp();
    check("pre_rst_rdata", 64'(RSP_RDATA), 64'hCAFE_F00D);
    release_rsp();

    busy_cycles = 20;
    send(1'b0, 1'b1, 1'b1, 2'b01, 32'h0);
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge CLK);
      if (!PHY_READY && !PHY_VALID && !REQ_READY && !RSP_VALID) got = 1'b1;
      n++;
    end
    check("reach_busy", 64'(got), 64'(1));
    @(posedge CLK); #1 RESETn = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check_reset_vals("midrst");
    @(posedge CLK); #1 RESETn = 1'b1;

    busy_cycles = 3; fin_si = mk_si(32'h0F0F_A5A5, 1'b0);
    send(1'b0, 1'b0, 1'b1, 2'b11, 32'h0);
    wait_rsp();
    check("post_rst_cmd_count", 64'(cmd_total - txn_base), 64'(1));
    check("post_rst_rdata", 64'(RSP_RDATA), 64'h0F0F_A5A5);
    check("post_rst_err", 64'(RSP_ERR), 64'(0));
    release_rsp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
